// File: rtl/qam_ctrl_pkg.sv
// Shared types and constants for the 16-QAM frame controllers.
package qam_ctrl_pkg;

  localparam int unsigned SYM_W = 4;
  localparam int unsigned LEN_W = 8;

  localparam logic [SYM_W-1:0] PRE_SYM_A = 4'h0;
  localparam logic [SYM_W-1:0] PRE_SYM_B = 4'hF;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    HEADER,
    PAYLOAD,
    GAP
  } state_e;

  // Preamble alternates A/B; odd symbol indices (0-based) carry B.
  function automatic logic [SYM_W-1:0] pre_sym(input logic odd);
    return odd ? PRE_SYM_B : PRE_SYM_A;
  endfunction

endpackage

// File: rtl/qam_frame_ctrl_if.sv
// Payload byte stream in and modulator symbol stream out of the frame controller.
interface qam_frame_ctrl_if;
  import qam_ctrl_pkg::*;

  logic             byte_valid;
  logic [LEN_W-1:0] byte_data;
  logic             byte_ready;
  logic             sym_valid;
  logic [SYM_W-1:0] sym_data;
  logic             sym_ready;

  modport master (
    input  byte_valid, byte_data, sym_ready,
    output byte_ready, sym_valid, sym_data
  );

  modport slave (
    output byte_valid, byte_data, sym_ready,
    input  byte_ready, sym_valid, sym_data
  );

endinterface

// File: rtl/qam_sym_out_reg.sv
// Valid/ready output holding register: loads when empty or drained, bubbles when the source is empty.
module qam_sym_out_reg #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         src_valid,
  input  logic [W-1:0] src_data,
  input  logic         out_ready,
  output logic         load,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    load    = !valid_q || out_ready;
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = src_valid;
      if (src_valid) begin
        data_d = src_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/qam_frame_ctrl.sv
// Transmit frame sequencer: preamble, length header, nibble-split payload, idle gap.
module qam_frame_ctrl
  import qam_ctrl_pkg::*;
#(
  parameter int unsigned PREAMBLE_LEN = 8,
  parameter int unsigned GAP_LEN      = 4
) (
  input  logic             axi_clk,
  input  logic             axi_rst,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  output logic             busy,
  output logic             frame_done,
  output logic             start_err,
  qam_frame_ctrl_if.master bus
);

  localparam int unsigned CNT_MAX = (PREAMBLE_LEN > GAP_LEN) ? PREAMBLE_LEN : GAP_LEN;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_LEN - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] bytes_left_q, bytes_left_d;
  logic             phase_q, phase_d;
  logic [SYM_W-1:0] lo_nib_q, lo_nib_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;
  logic             start_err_q, start_err_d;

  logic             src_valid;
  logic [SYM_W-1:0] src_data;
  logic             load;
  logic             byte_ready_c;
  logic             out_valid;
  logic [SYM_W-1:0] out_data;

  qam_sym_out_reg #(.W(SYM_W)) u_sym_out (
    .clk       (axi_clk),
    .rst       (axi_rst),
    .src_valid (src_valid),
    .src_data  (src_data),
    .out_ready (bus.sym_ready),
    .load      (load),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bytes_left_d = bytes_left_q;
    phase_d      = phase_q;
    lo_nib_d     = lo_nib_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    start_err_d  = 1'b0;
    src_valid    = 1'b0;
    src_data     = '0;
    byte_ready_c = 1'b0;

    unique case (state_q)
      IDLE: begin
        // The output stage is always empty here, so the first preamble
        // symbol is loaded on the same edge that accepts start.
        if (start) begin
          if (frame_len != '0) begin
            state_d      = PREAMBLE;
            bytes_left_d = frame_len;
            cnt_d        = CNT_W'(1);
            phase_d      = 1'b0;
            busy_d       = 1'b1;
            src_valid    = 1'b1;
            src_data     = PRE_SYM_A;
          end else begin
            start_err_d = 1'b1;
          end
        end
      end

      PREAMBLE: begin
        src_valid = 1'b1;
        src_data  = pre_sym(cnt_q[0]);
        if (load) begin
          if (cnt_q == PRE_LAST) begin
            state_d = HEADER;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      HEADER: begin
        src_valid = 1'b1;
        src_data  = cnt_q[0] ? bytes_left_q[3:0] : bytes_left_q[7:4];
        if (load) begin
          if (cnt_q[0]) begin
            state_d = PAYLOAD;
            cnt_d   = '0;
          end else begin
            cnt_d = CNT_W'(1);
          end
        end
      end

      PAYLOAD: begin
        if (phase_q) begin
          src_valid = 1'b1;
          src_data  = lo_nib_q;
          if (load) begin
            phase_d      = 1'b0;
            bytes_left_d = bytes_left_q - LEN_W'(1);
          end
        end else if (bytes_left_q != '0) begin
          byte_ready_c = load;
          src_valid    = bus.byte_valid;
          src_data     = bus.byte_data[7:4];
          if (load && bus.byte_valid) begin
            lo_nib_d = bus.byte_data[3:0];
            phase_d  = 1'b1;
          end
        end else if (load) begin
          // Last symbol has drained; this load leaves the stage empty.
          state_d = GAP;
          cnt_d   = '0;
        end
      end

      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d      = IDLE;
          cnt_d        = '0;
          busy_d       = 1'b0;
          frame_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bytes_left_q <= '0;
      phase_q      <= 1'b0;
      lo_nib_q     <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      start_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bytes_left_q <= bytes_left_d;
      phase_q      <= phase_d;
      lo_nib_q     <= lo_nib_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      start_err_q  <= start_err_d;
    end
  end

  assign busy           = busy_q;
  assign frame_done     = frame_done_q;
  assign start_err      = start_err_q;
  assign bus.byte_ready = byte_ready_c;
  assign bus.sym_valid  = out_valid;
  assign bus.sym_data   = out_data;

endmodule

// File: tb/tb_qam_frame_ctrl.sv
// Directed bench for qam_frame_ctrl (P=8, GAP=4).
module tb_qam_frame_ctrl;

  logic       axi_clk;
  logic       axi_rst;
  logic       start;
  logic [7:0] frame_len;
  logic       busy;
  logic       frame_done;
  logic       start_err;

  int checks;
  int failures;

  logic [7:0] tx_bytes [0:255];
  logic [3:0] exp_syms [0:1023];

  qam_frame_ctrl_if bus ();

  qam_frame_ctrl #(
    .PREAMBLE_LEN (8),
    .GAP_LEN      (4)
  ) dut (
    .axi_clk    (axi_clk),
    .axi_rst    (axi_rst),
    .start      (start),
    .frame_len  (frame_len),
    .busy       (busy),
    .frame_done (frame_done),
    .start_err  (start_err),
    .bus        (bus)
  );

  initial axi_clk = 1'b0;
  always #5 axi_clk = ~axi_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame A: len 2, bytes 3C A5
  task automatic load_frame_a();
    logic [3:0] tbl [0:13];
    tbl = '{4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF,
            4'h0, 4'h2, 4'h3, 4'hC, 4'hA, 4'h5};
    for (int i = 0; i < 14; i++) exp_syms[i] = tbl[i];
    tx_bytes[0] = 8'h3C;
    tx_bytes[1] = 8'hA5;
  endtask

  // Frame B: len 255, bytes 0..254
  task automatic load_frame_b();
    for (int i = 0; i < 8; i++) exp_syms[i] = (i % 2 == 1) ? 4'hF : 4'h0;
    exp_syms[8] = 4'hF;
    exp_syms[9] = 4'hF;
    for (int i = 0; i < 255; i++) begin
      tx_bytes[i]         = 8'(i);
      exp_syms[10 + 2*i]  = 4'(i / 16);
      exp_syms[11 + 2*i]  = 4'(i % 16);
    end
  endtask

  task automatic run_frame(input string tag, input bit chained, input bit keep_start,
                           input int len, input int next_len,
                           input int stall_lo, input int stall_hi, input int drop,
                           input int exp_done, input int exp_bubbles, input int n_exp);
    int got, bidx, drop_left, done_cyc, bubbles;
    logic prev_stall;
    logic [3:0] prev_data;
    got = 0; bidx = 0; drop_left = 0; done_cyc = -1; bubbles = 0;
    prev_stall = 1'b0; prev_data = '0;
    if (!chained) begin
      @(posedge axi_clk); #1;
      start = 1'b1; frame_len = 8'(len); bus.sym_ready = 1'b1; bus.byte_valid = 1'b0;
    end
    @(posedge axi_clk); #1;
    for (int cyc = 1; cyc <= 700; cyc++) begin
      start          = keep_start;
      frame_len      = 8'(next_len);
      bus.sym_ready  = !(cyc >= stall_lo && cyc <= stall_hi);
      bus.byte_valid = (drop_left == 0) && (bidx < len);
      bus.byte_data  = tx_bytes[bidx % 256];
      @(negedge axi_clk);
      if (cyc == 1) begin
        chk({tag, "_busy_c1"}, 32'(busy), 32'd1);
        chk({tag, "_first_sym"}, {27'd0, bus.sym_valid, bus.sym_data}, 32'h10);
      end
      if (prev_stall)
        chk({tag, "_hold"}, {27'd0, bus.sym_valid, bus.sym_data}, {27'd0, 1'b1, prev_data});
      prev_stall = bus.sym_valid && !bus.sym_ready;
      prev_data  = bus.sym_data;
      if (bus.sym_valid && bus.sym_ready) begin
        if (got < n_exp) chk({tag, "_sym"}, 32'(bus.sym_data), 32'(exp_syms[got]));
        got++;
      end else if (!bus.sym_valid && got < n_exp) begin
        bubbles++;
      end
      if (bus.byte_ready && bus.byte_valid) begin
        bidx++;
        if (bidx == 1) drop_left = drop;
      end else if (bus.byte_ready && drop_left > 0) begin
        drop_left--;
      end
      if (frame_done) begin
        done_cyc = cyc;
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        break;
      end
      @(posedge axi_clk); #1;
    end
    chk({tag, "_done_cycle"}, 32'(done_cyc), 32'(exp_done));
    chk({tag, "_sym_count"}, 32'(got), 32'(n_exp));
    chk({tag, "_bubbles"}, 32'(bubbles), 32'(exp_bubbles));
  endtask

  initial begin
    checks = 0; failures = 0;
    axi_rst = 1'b1; start = 1'b0; frame_len = '0;
    bus.byte_valid = 1'b0; bus.byte_data = '0; bus.sym_ready = 1'b1;
    for (int i = 0; i < 256; i++) tx_bytes[i] = '0;
    for (int i = 0; i < 1024; i++) exp_syms[i] = '0;

    // Reset state
    repeat (3) @(posedge axi_clk);
    #1;
    @(negedge axi_clk);
    chk("rst_sym_valid", 32'(bus.sym_valid), 32'd0);
    chk("rst_sym_data", 32'(bus.sym_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_start_err", 32'(start_err), 32'd0);
    chk("rst_byte_ready", 32'(bus.byte_ready), 32'd0);
    axi_rst = 1'b0;

    // Nominal frame
    load_frame_a();
    run_frame("nominal", 1'b0, 1'b0, 2, 2, 0, -1, 0, 19, 0, 14);

    // sym_ready low for cycles 10..12 (header low nibble held)
    run_frame("stall", 1'b0, 1'b0, 2, 2, 10, 12, 0, 22, 0, 14);

    // byte_valid low for 2 requested cycles before second byte
    run_frame("bubble", 1'b0, 1'b0, 2, 2, 0, -1, 2, 21, 2, 14);

    // Zero-length start
    @(posedge axi_clk); #1;
    start = 1'b1; frame_len = 8'd0;
    @(posedge axi_clk); #1;
    start = 1'b0;
    @(negedge axi_clk);
    chk("zlen_start_err_c1", 32'(start_err), 32'd1);
    chk("zlen_sym_valid_c1", 32'(bus.sym_valid), 32'd0);
    chk("zlen_busy_c1", 32'(busy), 32'd0);
    @(posedge axi_clk); #1;
    @(negedge axi_clk);
    chk("zlen_start_err_c2", 32'(start_err), 32'd0);
    chk("zlen_busy_c2", 32'(busy), 32'd0);
    chk("zlen_sym_valid_c2", 32'(bus.sym_valid), 32'd0);

    // Reset during PAYLOAD
    @(posedge axi_clk); #1;
    start = 1'b1; frame_len = 8'd2; bus.byte_valid = 1'b1; bus.byte_data = 8'h3C; bus.sym_ready = 1'b1;
    @(posedge axi_clk); #1;
    start = 1'b0;
    repeat (11) @(posedge axi_clk);
    #1;
    @(negedge axi_clk);
    chk("midrst_payload_sym", {27'd0, bus.sym_valid, bus.sym_data}, 32'h1C);
    axi_rst = 1'b1;
    @(posedge axi_clk); #1;
    axi_rst = 1'b0; bus.byte_valid = 1'b0;
    @(negedge axi_clk);
    chk("midrst_sym_valid", 32'(bus.sym_valid), 32'd0);
    chk("midrst_sym_data", 32'(bus.sym_data), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_frame_done", 32'(frame_done), 32'd0);
    chk("midrst_start_err", 32'(start_err), 32'd0);
    chk("midrst_byte_ready", 32'(bus.byte_ready), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge axi_clk); #1;
      @(negedge axi_clk);
      chk("midrst_quiet", {30'd0, frame_done, bus.sym_valid}, 32'd0);
    end
    run_frame("after_rst", 1'b0, 1'b0, 2, 2, 0, -1, 0, 19, 0, 14);

    // Back-to-back: start held through frame A (ignored mid-frame), accepted at frame_done
    run_frame("b2b_first", 1'b0, 1'b1, 2, 255, 0, -1, 0, 19, 0, 14);
    load_frame_b();
    run_frame("b2b_second", 1'b1, 1'b0, 255, 255, 0, -1, 0, 525, 0, 520);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/qam_frame_ctrl.md
# qam_frame_ctrl

Transmit-side frame sequencer for the 16-QAM modem. It sits between a byte-oriented data source and the modulator's 4-bit symbol input (`din_valid`/`din`/`din_ready`). On a start request it emits one frame: a fixed preamble, a two-symbol length header, the payload bytes split into nibbles, and an idle guard gap. It then reports completion. The demodulator sees a deterministic frame structure, and the modulator is never driven outside a frame.

## Interface
- `PREAMBLE_LEN`, 8: preamble symbol count; must be even and ≥2.
- `GAP_LEN`, 4: idle cycles after the last symbol; must be ≥1.
- `axi_clk`  in  1  clock.
- `axi_rst`  in  1  synchronous, active-high reset.
- `start`  in  1  frame request; sampled only in IDLE.
- `frame_len`  in  8  payload length in bytes; sampled with `start`.
- `byte_valid`  in  1  payload byte available.
- `byte_data`  in  8  payload byte.
- `byte_ready`  out  1  payload byte accepted when high together with `byte_valid`.
- `sym_valid`  out  1  to modulator `din_valid`.
- `sym_data`  out  4  to modulator `din`.
- `sym_ready`  in  1  from modulator `din_ready`.
- `busy`  out  1  high from the cycle after `start` is accepted until `frame_done`.
- `frame_done`  out  1  one-cycle pulse at frame end.
- `start_err`  out  1  one-cycle pulse when `start` arrives with `frame_len`==0.

## Operation
- **Reset values:** state IDLE. `sym_valid`, `byte_ready`, `busy`, `frame_done` and `start_err` are 0. `sym_data` is 0. All counters are 0.
- **Output stage:** registered, AXI-stream rules apply.
  - Once `sym_valid` is 1, `sym_data` is held until `sym_ready`=1.
  - The stage loads a new symbol when `!sym_valid || sym_ready`.
  - If no symbol is available at load time, `sym_valid` goes to 0 (a bubble). No filler symbols are inserted.
- **IDLE:**
  - `start`=1 with `frame_len`≠0: latch the length, go to PREAMBLE, set `busy`.
  - `start`=1 with `frame_len`=0: pulse `start_err` next cycle and stay in IDLE.
- **`start` while not in IDLE:** ignored. No error, and no queueing.
- **PREAMBLE:** emit `PREAMBLE_LEN` symbols alternating `PRE_SYM_A` (4'h0) and `PRE_SYM_B` (4'hF), starting with A. The counter advances only on load.
- **HEADER:** emit `len[7:4]`, then `len[3:0]`.
- **PAYLOAD:**
  - `byte_ready` = state==PAYLOAD && nibble phase 0 && bytes_left≠0 && (`!sym_valid || sym_ready`).
  - On a byte handshake, load `byte_data[7:4]`, store `byte_data[3:0]` and set phase 1.
  - On the next load, emit the stored low nibble, clear the phase and decrement bytes_left.
  - `byte_valid`=0 at phase 0 produces a bubble.
  - Enter GAP when bytes_left reaches 0 and the last symbol has been accepted (handshake complete, `sym_valid` then 0).
- **GAP:** `sym_valid`=0 for `GAP_LEN` cycles. Then go to IDLE, pulse `frame_done` and drop `busy` in the same cycle. A `start` in that IDLE cycle is accepted.
- **Reset mid-frame:** the frame is abandoned immediately. All outputs return to reset values next cycle. No `frame_done`.
- **Counter widths:** preamble/gap counter `$clog2(max(PREAMBLE_LEN,GAP_LEN)+1)` bits. bytes_left 8 bits, which never wraps because decrement happens only when it is ≠0.

## Timing
- `start` accepted in cycle 0: `busy`=1 and `sym_valid`=1 with the first preamble symbol in cycle 1.
- With `sym_ready`=1 and `byte_valid`=1 continuously, there is one symbol per cycle:
  - preamble in cycles 1..P;
  - header in cycles P+1 and P+2;
  - payload in cycles P+3..P+2+2L;
  - gap in the next `GAP_LEN` cycles;
  - `frame_done` in cycle P+2+2L+GAP_LEN+1.
- Each `sym_ready`=0 cycle while `sym_valid`=1 delays the remaining schedule by exactly one cycle.
- Each bubble caused by `byte_valid`=0 delays the remaining schedule by one cycle.
- `byte_ready` has combinational dependence on `sym_ready` only. No combinational path exists from `byte_valid` to any output.

## Structure
- Package `qam_ctrl_pkg`:
  - state enum `{IDLE, PREAMBLE, HEADER, PAYLOAD, GAP}`;
  - `PRE_SYM_A`, `PRE_SYM_B`;
  - `SYM_W`=4, `LEN_W`=8.
- One sub-module, `qam_sym_out_reg`: a valid/ready output holding register with load-enable and bubble handling. It is reused later for the receive-side controller.
- The top of `qam_frame_ctrl` holds the FSM, counters and nibble register. Its symbol outputs connect directly to the modulator inputs at the modem top level.

## Test plan
- P=8, GAP=4, `frame_len`=2, bytes 0x3C, 0xA5, `sym_ready`=1: expect symbols 0,F,0,F,0,F,0,F,0,2,3,C,A,5 in cycles 1–14, `frame_done` in cycle 19, `busy` 1→0 at cycle 19.
- Same frame with `sym_ready` low for 3 cycles during the header: `sym_data` is held stable while stalled, and `frame_done` comes in cycle 22.
- `byte_valid` dropped for 2 cycles before the second byte: 2-cycle `sym_valid` bubble, no duplicate or filler symbols, `frame_done` in cycle 21.
- `start` with `frame_len`=0: `start_err` pulse in cycle 1, no `sym_valid`, and `busy` stays 0. `start` repeated mid-frame is ignored.
- `axi_rst` asserted during PAYLOAD: all outputs reach reset values the next cycle, no `frame_done`. A new `start` then produces a fresh preamble.
- Back-to-back frames (`start` in the `frame_done` cycle, `frame_len`=255): 510 payload symbols, and the second frame's preamble starts one cycle after `frame_done`.
